// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/arithmetic/compare ops, iterative one-bit-per-cycle shifts.
// start/busy/done handshake; result stays registered until the next accepted operation.
module seq_alu #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        operation,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic              busy,
  output logic              done,
  output logic [XLEN-1:0]   result,
  output logic              zero
);

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_SLL = 4'd2;
  localparam logic [3:0] ALU_SRL = 4'd3;
  localparam logic [3:0] ALU_SRA = 4'd4;
  localparam logic [3:0] ALU_LT  = 4'd5;
  localparam logic [3:0] ALU_LTU = 4'd6;
  localparam logic [3:0] ALU_XOR = 4'd7;
  localparam logic [3:0] ALU_OR  = 4'd8;
  localparam logic [3:0] ALU_AND = 4'd9;
  localparam logic [3:0] ALU_EQ  = 4'd10;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  typedef enum logic [1:0] {
    SH_LL,
    SH_RL,
    SH_RA
  } shift_kind_t;

  state_t              state_reg, state_next;
  shift_kind_t         kind_reg, kind_next;
  logic [XLEN-1:0]     result_reg, result_next;
  logic [SHAMT_W-1:0]  count_reg, count_next;
  logic                sign_reg, sign_next;
  logic                done_reg, done_next;

  logic [SHAMT_W-1:0]  shamt;
  logic                is_shift;
  shift_kind_t         kind_decoded;
  logic [XLEN-1:0]     sum, diff;
  logic                lt_flag, ltu_flag, eq_flag;
  logic [XLEN-1:0]     xor_bits, or_bits, and_bits;
  logic [XLEN-1:0]     shl_one, shr_one;
  logic                fill_bit;
  logic [XLEN-1:0]     single_result;

  assign shamt    = b[SHAMT_W-1:0];
  assign sum      = a + b;
  assign diff     = a - b;
  assign lt_flag  = $signed(a) < $signed(b);
  assign ltu_flag = a < b;
  assign eq_flag  = a == b;

  // Right shifts inject either zero or the sign bit captured at acceptance.
  assign fill_bit = (kind_reg == SH_RA) ? sign_reg : 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi < XLEN; gi++) begin : g_bit
      assign xor_bits[gi] = a[gi] ^ b[gi];
      assign or_bits[gi]  = a[gi] | b[gi];
      assign and_bits[gi] = a[gi] & b[gi];

      if (gi == 0) begin : g_lsb
        assign shl_one[gi] = 1'b0;
      end else begin : g_upper
        assign shl_one[gi] = result_reg[gi-1];
      end

      if (gi == XLEN - 1) begin : g_msb
        assign shr_one[gi] = fill_bit;
      end else begin : g_lower
        assign shr_one[gi] = result_reg[gi+1];
      end
    end
  endgenerate

  always_comb begin
    is_shift     = 1'b0;
    kind_decoded = SH_LL;
    case (operation)
      ALU_SLL: begin is_shift = 1'b1; kind_decoded = SH_LL; end
      ALU_SRL: begin is_shift = 1'b1; kind_decoded = SH_RL; end
      ALU_SRA: begin is_shift = 1'b1; kind_decoded = SH_RA; end
      default: begin is_shift = 1'b0; kind_decoded = SH_LL; end
    endcase
  end

  // Shifts only land here with a zero amount, so they pass operand A through.
  always_comb begin
    single_result = '0;
    case (operation)
      ALU_ADD: single_result = sum;
      ALU_SUB: single_result = diff;
      ALU_SLL,
      ALU_SRL,
      ALU_SRA: single_result = a;
      ALU_LT:  single_result = {{(XLEN-1){1'b0}}, lt_flag};
      ALU_LTU: single_result = {{(XLEN-1){1'b0}}, ltu_flag};
      ALU_XOR: single_result = xor_bits;
      ALU_OR:  single_result = or_bits;
      ALU_AND: single_result = and_bits;
      ALU_EQ:  single_result = {{(XLEN-1){1'b0}}, eq_flag};
      default: single_result = '0;
    endcase
  end

  always_comb begin
    state_next  = state_reg;
    kind_next   = kind_reg;
    result_next = result_reg;
    count_next  = count_reg;
    sign_next   = sign_reg;
    done_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (is_shift && (shamt != '0)) begin
            result_next = a;
            count_next  = shamt;
            kind_next   = kind_decoded;
            sign_next   = a[XLEN-1];
            state_next  = SHIFT;
          end else begin
            result_next = single_result;
            done_next   = 1'b1;
          end
        end
      end
      SHIFT: begin
        result_next = (kind_reg == SH_LL) ? shl_one : shr_one;
        count_next  = count_reg - 1'b1;
        if (count_reg == SHAMT_W'(1)) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      kind_reg   <= SH_LL;
      result_reg <= '0;
      count_reg  <= '0;
      sign_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      kind_reg   <= kind_next;
      result_reg <= result_next;
      count_reg  <= count_next;
      sign_reg   <= sign_next;
      done_reg   <= done_next;
    end
  end

  assign busy   = (state_reg == SHIFT);
  assign done   = done_reg;
  assign result = result_reg;
  assign zero   = (result_reg == '0);

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed cases from the test plan plus random operations
// checked against an arithmetic reference model.
module tb_seq_alu;

  localparam int XLEN    = 32;
  localparam int SHAMT_W = 5;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_SLL = 4'd2;
  localparam logic [3:0] ALU_SRL = 4'd3;
  localparam logic [3:0] ALU_SRA = 4'd4;
  localparam logic [3:0] ALU_LT  = 4'd5;
  localparam logic [3:0] ALU_LTU = 4'd6;
  localparam logic [3:0] ALU_XOR = 4'd7;
  localparam logic [3:0] ALU_OR  = 4'd8;
  localparam logic [3:0] ALU_AND = 4'd9;
  localparam logic [3:0] ALU_EQ  = 4'd10;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [3:0]      operation;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic            zero;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_alu #(.XLEN(XLEN), .SHAMT_W(SHAMT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .operation (operation),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .zero      (zero)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    int unsigned sh;
    sh = int'(y[4:0]);
    case (op)
      ALU_ADD: return x + y;
      ALU_SUB: return x - y;
      ALU_SLL: return x << sh;
      ALU_SRL: return x >> sh;
      ALU_SRA: return $unsigned($signed(x) >>> sh);
      ALU_LT:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      ALU_LTU: return (x < y) ? 32'd1 : 32'd0;
      ALU_XOR: return x ^ y;
      ALU_OR:  return x | y;
      ALU_AND: return x & y;
      ALU_EQ:  return (x == y) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int model_busy(input logic [3:0] op, input logic [31:0] y);
    if (op == ALU_SLL || op == ALU_SRL || op == ALU_SRA) return int'(y[4:0]);
    return 0;
  endfunction

  // Issues one op from #1 after an edge; returns positioned in its done cycle.
  task automatic issue(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                       input bit poke_busy, input string tag);
    logic [31:0] exp;
    int          want;
    int          cycles;
    exp  = model(op, x, y);
    want = model_busy(op, y);
    start = 1'b1; operation = op; a = x; b = y;
    @(posedge clk); #1;
    start  = 1'b0;
    cycles = 0;
    if (poke_busy) begin
      start = 1'b1; operation = ALU_ADD;
    end
    while (busy === 1'b1 && cycles < 64) begin
      check({tag, " done-low-while-busy"}, {31'b0, done}, 32'd0);
      a = $urandom; b = $urandom;
      @(posedge clk); #1;
      cycles++;
    end
    start = 1'b0;
    check({tag, " busy-cycles"}, 32'(cycles), 32'(want));
    check({tag, " busy"},   {31'b0, busy}, 32'd0);
    check({tag, " done"},   {31'b0, done}, 32'd1);
    check({tag, " result"}, result, exp);
    check({tag, " zero"},   {31'b0, zero}, {31'b0, exp == 32'd0});
    $display("op=%0d a=0x%08h b=0x%08h busy_cycles=%0d result=0x%08h expected=0x%08h [%s]",
             op, x, y, cycles, result, exp, tag);
  endtask

  initial begin
    logic [3:0]  rop;
    logic [31:0] ra, rb, hold;

    rst = 1'b1; start = 1'b0; operation = ALU_ADD; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy",   {31'b0, busy}, 32'd0);
    check("reset done",   {31'b0, done}, 32'd0);
    check("reset result", result, 32'd0);
    check("reset zero",   {31'b0, zero}, 32'd1);
    rst = 1'b0;

    issue(ALU_ADD, 32'd5, 32'd7, 1'b0, "add 5+7");
    issue(ALU_SUB, 32'd7, 32'd7, 1'b0, "sub 7-7");
    issue(ALU_LT,  32'hFFFF_FFFF, 32'd0, 1'b0, "lt signed");
    issue(ALU_LTU, 32'hFFFF_FFFF, 32'd0, 1'b0, "ltu");
    issue(ALU_EQ,  32'h1234, 32'h1234, 1'b0, "eq");
    issue(ALU_SLL, 32'd1, 32'd31, 1'b0, "sll by 31");
    issue(ALU_SLL, 32'd1, 32'h20, 1'b0, "sll shamt 0");
    issue(ALU_SRA, 32'h8000_0000, 32'd4, 1'b0, "sra by 4");
    issue(ALU_SRL, 32'h8000_0000, 32'd4, 1'b0, "srl by 4");
    issue(ALU_SLL, 32'd3, 32'd10, 1'b1, "sll start ignored");

    // Back-to-back: a new op accepted in the done cycle.
    start = 1'b1; operation = ALU_ADD; a = 32'd9; b = 32'd4;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b done",   {31'b0, done}, 32'd1);
    check("b2b busy",   {31'b0, busy}, 32'd0);
    check("b2b result", result, 32'd13);
    $display("op=%0d a=0x%08h b=0x%08h back-to-back result=0x%08h", ALU_ADD, 32'd9, 32'd4, result);
    @(posedge clk); #1;
    check("b2b done drop", {31'b0, done}, 32'd0);
    check("b2b hold",      result, 32'd13);

    issue(4'hF, 32'hDEAD_BEEF, 32'h1, 1'b0, "undefined op");

    // Reset in the middle of a shift.
    start = 1'b1; operation = ALU_SLL; a = 32'h0000_FFFF; b = 32'd20;
    @(posedge clk); #1;
    start = 1'b0;
    check("pre-rst busy", {31'b0, busy}, 32'd1);
    repeat (5) @(posedge clk);
    #1; rst = 1'b1; #1;
    check("midrst busy",   {31'b0, busy}, 32'd0);
    check("midrst done",   {31'b0, done}, 32'd0);
    check("midrst result", result, 32'd0);
    check("midrst zero",   {31'b0, zero}, 32'd1);
    $display("reset asserted mid-shift result=0x%08h", result);
    @(posedge clk); #1;
    rst = 1'b0;
    issue(ALU_ADD, 32'd2, 32'd3, 1'b0, "add after reset");

    for (int i = 0; i < 40; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = $urandom;
      if (i % 8 == 0) rb = ra;
      issue(rop, ra, rb, 1'($urandom_range(0, 1)), "random");
      hold = model(rop, ra, rb);
      @(posedge clk); #1;
      check("random done drop", {31'b0, done}, 32'd0);
      check("random hold",      result, hold);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
# seq_alu

Multi-cycle ALU that sits directly downstream of the ALU control decoder and consumes its 4-bit `operation` code. It executes logic, arithmetic and compare operations in one cycle and performs shifts iteratively, one bit per cycle, to cut shifter area. It exposes a start/busy/done handshake to the datapath sequencer and holds the registered result until the next accepted operation.

## Interface
- `XLEN`, 32, operand and result width.
- `SHAMT_W`, 5, shift-amount width; must equal $clog2(XLEN).

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only while `busy`=0.
- `operation`  in  4  ALU code from `defines.v`: `ALU_ADD`, `ALU_SUB`, `ALU_SLL`, `ALU_SRL`, `ALU_SRA`, `ALU_LT`, `ALU_LTU`, `ALU_XOR`, `ALU_OR`, `ALU_AND`, `ALU_EQ`.
- `a`  in  XLEN  operand A.
- `b`  in  XLEN  operand B; for shifts, only `b[SHAMT_W-1:0]` is used.
- `busy`  out  1  an iterative shift is in progress.
- `done`  out  1  one-cycle pulse; `result` is valid from this cycle onward.
- `result`  out  XLEN  registered result.
- `zero`  out  1  `result`==0, derived combinationally from the result register.

## Operation
- States: IDLE, SHIFT. Reset enters IDLE with `busy`=0, `done`=0, `result`=0, shift counter=0, `zero`=1.
- IDLE with `start`=1 at an edge latches the operation:
  - Non-shift op, or shift with shamt=0: `result` loaded at that edge. `done`=1 for the following cycle. State stays IDLE.
  - Shift with shamt=n>0: `result`←`a`, counter←n, direction and type latched, sign bit latched as `a[XLEN-1]`. Go to SHIFT with `busy`=1.
- SHIFT: each edge shifts `result` by one bit and decrements the counter.
  - SLL fills with 0. SRL fills with 0. SRA fills with the latched sign bit.
  - When the counter goes 1→0: go to IDLE, `busy`=0, `done`=1 for the next cycle.
- Arithmetic rules:
  - ADD/SUB: modulo 2^XLEN, no carry or overflow output.
  - LT: signed compare; LTU: unsigned compare; EQ: equality. Each gives `{XLEN-1 zeros, flag}`.
  - XOR/OR/AND: bitwise.
- An undefined `operation` code yields `result`=0 and is handled like a one-cycle op.
- `start` while `busy`=1 is ignored. Operands and operation may change freely during SHIFT without effect.
- `result` holds its value between operations; `done` is low in every cycle not specified above.

## Timing
- One-cycle ops: `start` sampled at edge E0; `result` and `done` valid after E0. Latency is 1.
- Shift by n>0: accepted at E0; `busy` high after E0 through En; `result` final and `done`=1 after En. Latency is n+1 edges, with `busy` high for n cycles.
- Back-to-back: `start` may be high in the same cycle `done` is high, since the block is IDLE then. The new op is accepted at that edge, and `done` stays high one more cycle if the new op is one-cycle.
- `rst` asserted at any time, including mid-SHIFT, forces reset values immediately and discards the pending shift. The first `start` is honoured at the first rising edge after `rst` deasserts.
- `zero` tracks `result` with no added latency.

## Test plan
- ADD a=5, b=7 → one cycle later `result`=12, `done`=1, `zero`=0. SUB a=7, b=7 → `result`=0, `zero`=1.
- LT a=0xFFFFFFFF, b=0 → `result`=1. LTU with the same operands → `result`=0. EQ a=b=0x1234 → `result`=1.
- SLL a=1, b=31 → `busy`=1 for 31 cycles, then `done` with `result`=0x80000000. SLL b=0x20 (shamt=0) → one-cycle `done` with `result`=1.
- SRA a=0x80000000, b=4 → `result`=0xF8000000 after 5 edges. SRL with the same operands → `result`=0x08000000.
- `start`=1 with ADD during a 10-bit shift → ignored; shift result unchanged. ADD issued in the `done` cycle → accepted, `result` valid one cycle later.
- `rst` pulsed mid-shift → `busy`=0, `done`=0, `result`=0 immediately. A following ADD 2+3 → `result`=5 after one cycle.
